vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  CLK_DIV   4    clk cycles per pixel, >=1
  H_ACTIVE  640  visible pixels per line
  H_FP      16   horizontal front porch, pixels
  H_SYNC    96   horizontal sync width, pixels
  H_BP      48   horizontal back porch, pixels
  V_ACTIVE  480  visible lines per frame
  V_FP      10   vertical front porch, lines
  V_SYNC    2    vertical sync width, lines
  V_BP      29   vertical back porch, lines
  SYNC_POL  0    sync active level (0 = active-low)
  HW        10   width of h_count / pixel_x
  VW        10   width of v_count / pixel_y
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  clk         in   1   system clock; one clock only
  reset       in   1   synchronous, active-high reset
  en          in   1   advance enable; low freezes all state
  pix_tick    out  1   1-clk strobe, one per pixel period
  h_count     out  HW  horizontal position, 0..H_TOTAL-1
  v_count     out  VW  vertical position, 0..V_TOTAL-1
  hsync       out  1   horizontal sync, SYNC_POL when active
  vsync       out  1   vertical sync, SYNC_POL when active
  display_en  out  1   high in visible region
  line_end    out  1   1-clk strobe on last pixel tick of a line
  frame_end   out  1   1-clk strobe on last pixel tick of a frame

Function
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP; defaults SHALL give 800 and 521.
REQ-004 An internal divider SHALL count 0..CLK_DIV-1 on each clk with en high, wrapping to 0; pix_tick = en && divider==CLK_DIV-1. With CLK_DIV=1, pix_tick = en.
REQ-005 h_count SHALL increment only on pix_tick and SHALL wrap from H_TOTAL-1 to 0.
REQ-006 v_count SHALL increment only on a pix_tick with h_count==H_TOTAL-1, wrapping from V_TOTAL-1 to 0 in the same cycle h_count wraps.
REQ-007 line_end = pix_tick && h_count==H_TOTAL-1; frame_end = line_end && v_count==V_TOTAL-1.
REQ-008 hsync SHALL equal SYNC_POL when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL.
REQ-009 vsync SHALL equal SYNC_POL when V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC, else ~SYNC_POL, independent of h_count.
REQ-010 display_en = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
REQ-011 hsync, vsync, display_en SHALL be decodes of the current registered counters: zero latency and cycle-aligned with h_count/v_count.
REQ-012 en low SHALL hold divider, h_count and v_count; pix_tick, line_end and frame_end SHALL be 0 while en is low; resuming SHALL continue from the held count with no skipped or repeated pixel.
REQ-013 Arithmetic SHALL be unsigned; counters SHALL never exceed TOTAL-1; HW/VW too narrow for H_TOTAL-1/V_TOTAL-1 is a configuration error flagged at elaboration.

Reset
REQ-014 reset is sampled on rising clk edges only and takes priority over en.
REQ-015 After reset: divider=0, h_count=0, v_count=0, pix_tick=0 (when CLK_DIV>1), line_end=0, frame_end=0, hsync=vsync=~SYNC_POL, display_en=1.
REQ-016 reset asserted mid-line or mid-frame SHALL return all state to REQ-015 values on the next edge, with no partial strobe.

Verification
REQ-017 Defaults, en=1, reset released at cycle 0 -> pix_tick every 4th clk (cycles 3, 7, ...); first line_end at clk 3199; h_count=0 at clk 3200, v_count=1.
REQ-018 Defaults -> hsync low for exactly 384 clk (h_count 656..751, clk 2624..3007 of each line); display_en high for h_count 0..639 only.
REQ-019 Defaults -> vsync low for v_count 490..491 (6400 clk); frame_end once per 1,667,200 clk, followed by h_count=v_count=0.
REQ-020 en low for 10 clk at h_count=100 -> all outputs frozen, no strobes; after en high, h_count=101 exactly 4 enabled clk later.
REQ-021 reset pulsed at h_count=700, v_count=491 -> next cycle all values per REQ-015; hsync and vsync return to high.
REQ-022 CLK_DIV=1, H 8/1/2/1, V 4/1/1/1, SYNC_POL=1 -> line period 12 clk, frame 84 clk, hsync high at h_count 9..10, vsync high at v_count 5.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA-style raster timing generator: pixel-rate divider, h/v position counters,
// sync/visible decodes and line/frame strobes.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 29,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned HW       = 10,
  parameter int unsigned VW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          pix_tick,
  output logic [HW-1:0] h_count,
  output logic [VW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          display_en,
  output logic          line_end,
  output logic          frame_end
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Decode bounds may equal TOTAL, so compare one bit wider than the counters
  localparam int unsigned HXW     = HW + 1;
  localparam int unsigned VXW     = VW + 1;

  localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]  H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]  V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [HXW-1:0] H_VIS_END = HXW'(H_ACTIVE);
  localparam logic [HXW-1:0] HS_BEG    = HXW'(H_ACTIVE + H_FP);
  localparam logic [HXW-1:0] HS_END    = HXW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VXW-1:0] V_VIS_END = VXW'(V_ACTIVE);
  localparam logic [VXW-1:0] VS_BEG    = VXW'(V_ACTIVE + V_FP);
  localparam logic [VXW-1:0] VS_END    = VXW'(V_ACTIVE + V_FP + V_SYNC);

  // Reject configurations whose counters cannot hold their last position
  if (CLK_DIV < 1) begin : g_err_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end
  if (64'(H_TOTAL) > (64'd1 << HW)) begin : g_err_hw
    $error("vga_timing_gen: HW too narrow for H_TOTAL-1");
  end
  if (64'(V_TOTAL) > (64'd1 << VW)) begin : g_err_vw
    $error("vga_timing_gen: VW too narrow for V_TOTAL-1");
  end

  logic [DW-1:0]  div_q, div_d;
  logic [HW-1:0]  h_q, h_d;
  logic [VW-1:0]  v_q, v_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           de_q, de_d;
  logic [HXW-1:0] h_ext;
  logic [VXW-1:0] v_ext;

  // Strobes follow en immediately so nothing fires while frozen
  assign pix_tick  = en && (div_q == DIV_LAST);
  assign line_end  = pix_tick && (h_q == H_LAST);
  assign frame_end = line_end && (v_q == V_LAST);

  // Next-state counters; decodes are taken from next state so the registered
  // sync/visible flags stay cycle-aligned with the registered counters
  always_comb begin
    div_d   = div_q;
    h_d     = h_q;
    v_d     = v_q;
    h_ext   = '0;
    v_ext   = '0;
    hsync_d = ~SYNC_POL;
    vsync_d = ~SYNC_POL;
    de_d    = 1'b0;

    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end

    if (pix_tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end

    h_ext = {1'b0, h_d};
    v_ext = {1'b0, v_d};
    if ((h_ext >= HS_BEG) && (h_ext < HS_END)) hsync_d = SYNC_POL;
    if ((v_ext >= VS_BEG) && (v_ext < VS_END)) vsync_d = SYNC_POL;
    de_d = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b1;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
    end
  end

  assign h_count    = h_q;
  assign v_count    = v_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_en = de_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked every cycle against an
// arithmetic raster model, plus directed timing, freeze and reset scenarios.
module tb_vga_timing_gen;

  localparam int CD  [3] = '{4, 1, 3};
  localparam int HA  [3] = '{640, 8, 20};
  localparam int HF  [3] = '{16, 1, 2};
  localparam int HS  [3] = '{96, 2, 3};
  localparam int HB  [3] = '{48, 1, 2};
  localparam int VA  [3] = '{480, 4, 10};
  localparam int VF  [3] = '{10, 1, 2};
  localparam int VS  [3] = '{2, 1, 2};
  localparam int VB  [3] = '{29, 1, 3};
  localparam int POL [3] = '{0, 1, 0};
  localparam int TH  [3] = '{700, 9, 23};
  localparam int TV  [3] = '{0, 5, 12};

  logic       clk;
  logic [2:0] rst;
  logic [2:0] en;

  logic       pt0, le0, fe0, hs0, vs0, de0;
  logic [9:0] h0, v0;
  logic       pt1, le1, fe1, hs1, vs1, de1;
  logic [3:0] h1;
  logic [2:0] v1;
  logic       pt2, le2, fe2, hs2, vs2, de2;
  logic [4:0] h2, v2;

  longint n [3];
  int     checks;
  int     errors;
  bit     chk_on;

  vga_timing_gen u_dut0 (
    .clk(clk), .reset(rst[0]), .en(en[0]), .pix_tick(pt0), .h_count(h0), .v_count(v0),
    .hsync(hs0), .vsync(vs0), .display_en(de0), .line_end(le0), .frame_end(fe0)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1), .HW(4), .VW(3)
  ) u_dut1 (
    .clk(clk), .reset(rst[1]), .en(en[1]), .pix_tick(pt1), .h_count(h1), .v_count(v1),
    .hsync(hs1), .vsync(vs1), .display_en(de1), .line_end(le1), .frame_end(fe1)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0), .HW(5), .VW(5)
  ) u_dut2 (
    .clk(clk), .reset(rst[2]), .en(en[2]), .pix_tick(pt2), .h_count(h2), .v_count(v2),
    .hsync(hs2), .vsync(vs2), .display_en(de2), .line_end(le2), .frame_end(fe2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Layout: {pix_tick, line_end, frame_end, hsync, vsync, display_en, h[15:0], v[15:0]}
  function automatic logic [37:0] obs_vec(input int k);
    case (k)
      0:       return {pt0, le0, fe0, hs0, vs0, de0, 16'(h0), 16'(v0)};
      1:       return {pt1, le1, fe1, hs1, vs1, de1, 16'(h1), 16'(v1)};
      default: return {pt2, le2, fe2, hs2, vs2, de2, 16'(h2), 16'(v2)};
    endcase
  endfunction

  // Raster position derived from the number of enabled clocks since reset
  function automatic logic [37:0] model_vec(input int k, input logic e);
    longint ht, vt, p, d, h, v;
    bit ptv, lev, fev, hsv, vsv, dev;
    ht  = HA[k] + HF[k] + HS[k] + HB[k];
    vt  = VA[k] + VF[k] + VS[k] + VB[k];
    p   = n[k] / CD[k];
    d   = n[k] % CD[k];
    h   = p % ht;
    v   = (p / ht) % vt;
    ptv = e && (d == CD[k] - 1);
    lev = ptv && (h == ht - 1);
    fev = lev && (v == vt - 1);
    hsv = (h >= HA[k] + HF[k] && h < HA[k] + HF[k] + HS[k]) ? (POL[k] != 0) : (POL[k] == 0);
    vsv = (v >= VA[k] + VF[k] && v < VA[k] + VF[k] + VS[k]) ? (POL[k] != 0) : (POL[k] == 0);
    dev = (h < HA[k]) && (v < VA[k]);
    return {ptv, lev, fev, hsv, vsv, dev, 16'(h), 16'(v)};
  endfunction

  function automatic bit hit(input int k);
    longint ht, vt, p;
    ht = HA[k] + HF[k] + HS[k] + HB[k];
    vt = VA[k] + VF[k] + VS[k] + VB[k];
    p  = n[k] / CD[k];
    return (n[k] % CD[k] == 0) && (p % ht == TH[k]) && (k == 0 || (p / ht) % vt == TV[k]);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model dut%0d n=%0d", k, n[k]), 64'(obs_vec(k)), 64'(model_vec(k, en[k])));
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) n[k] = 0;
      else if (en[k]) n[k] = n[k] + 1;
    end
    @(negedge clk);
  endtask

  initial begin
    int hs_low, hs_first, hs_last, de_cnt;
    int last_le1, last_fe1, last_fe2;
    bit found;
    logic [37:0] ov;

    checks = 0;
    errors = 0;
    chk_on = 1'b0;
    rst    = 3'b111;
    en     = 3'b000;
    for (int k = 0; k < 3; k++) n[k] = 0;

    @(negedge clk);
    settle();
    advance();
    rst    = 3'b000;
    en     = 3'b111;
    chk_on = 1'b1;

    // Free run from reset release: pixel, line and frame timing
    hs_low = 0; hs_first = -1; hs_last = -1; de_cnt = 0;
    last_le1 = -100; last_fe1 = -100; last_fe2 = -100;
    for (int c = 0; c < 6400; c++) begin
      settle();
      if (c == 0) begin
        chk("rst0_state", 64'(obs_vec(0)), 64'({6'b000111, 16'd0, 16'd0}));
        chk("rst1_state", 64'(obs_vec(1)), 64'({6'b100001, 16'd0, 16'd0}));
      end
      if (c == 2) chk("pix_tick_c2", 64'(pt0), 64'(0));
      if (c == 3) chk("pix_tick_c3", 64'(pt0), 64'(1));
      if (c == 7) chk("pix_tick_c7", 64'(pt0), 64'(1));
      if (c == 3198) chk("line_end_c3198", 64'(le0), 64'(0));
      if (hs0 === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = c % 3200;
        hs_last = c % 3200;
      end
      if (de0 === 1'b1) de_cnt++;
      if (c == 3199 || c == 6399) begin
        chk("line_end_last", 64'(le0), 64'(1));
        chk("hsync_low_len", 64'(hs_low), 64'(384));
        chk("hsync_first", 64'(hs_first), 64'(2624));
        chk("hsync_last", 64'(hs_last), 64'(3007));
        chk("de_len", 64'(de_cnt), 64'(2560));
        hs_low = 0; hs_first = -1; hs_last = -1; de_cnt = 0;
      end
      if (c == 3200) begin
        chk("h_after_line", 64'(h0), 64'(0));
        chk("v_after_line", 64'(v0), 64'(1));
      end
      if (c == last_fe1 + 1) begin
        chk("wrap1_h", 64'(h1), 64'(0));
        chk("wrap1_v", 64'(v1), 64'(0));
      end
      if (c == last_fe2 + 1) begin
        chk("wrap2_h", 64'(h2), 64'(0));
        chk("wrap2_v", 64'(v2), 64'(0));
      end
      if (le1 === 1'b1) begin
        if (last_le1 >= 0) chk("line_period1", 64'(c - last_le1), 64'(12));
        last_le1 = c;
      end
      if (fe1 === 1'b1) begin
        if (last_fe1 >= 0) chk("frame_period1", 64'(c - last_fe1), 64'(84));
        last_fe1 = c;
      end
      if (fe2 === 1'b1) begin
        if (last_fe2 >= 0) chk("frame_period2", 64'(c - last_fe2), 64'(1377));
        last_fe2 = c;
      end
      advance();
    end

    // Freeze at h_count=100 for 10 clocks, then resume
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (n[0] % 4 == 0 && (n[0] / 4) % 800 == 100) begin
        found = 1'b1;
        break;
      end
      settle();
      advance();
    end
    chk("reach_h100", 64'(found), 64'(1));
    en = 3'b000;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("frozen_h", 64'(h0), 64'(100));
      chk("frozen_strobes", 64'({pt0, le0, fe0, pt1, le1, fe1}), 64'(0));
      advance();
    end
    en = 3'b111;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("resume_h", 64'(h0), 64'(100));
      chk("resume_tick", 64'(pt0), 64'(i == 3));
      advance();
    end
    settle();
    chk("resume_h101", 64'(h0), 64'(101));
    advance();

    // Random enable gaps and occasional resets
    for (int i = 0; i < 6000; i++) begin
      for (int k = 0; k < 3; k++) begin
        en[k]  = ($urandom_range(0, 3) != 0);
        rst[k] = ($urandom_range(0, 599) == 0);
      end
      settle();
      advance();
    end
    rst = 3'b000;
    en  = 3'b111;

    // Reset pulsed while sync pulses are active
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if (hit(k)) begin
          found = 1'b1;
          break;
        end
        settle();
        advance();
      end
      chk($sformatf("reach_target%0d", k), 64'(found), 64'(1));
      rst[k] = 1'b1;
      settle();
      ov = obs_vec(k);
      chk($sformatf("pre_rst_hsync%0d", k), 64'(ov[34]), 64'(POL[k] != 0));
      if (k != 0) chk($sformatf("pre_rst_vsync%0d", k), 64'(ov[33]), 64'(POL[k] != 0));
      advance();
      rst[k] = 1'b0;
      settle();
      ov = obs_vec(k);
      chk($sformatf("post_rst%0d", k), 64'(ov),
          64'({(CD[k] == 1), 2'b00, (POL[k] == 0), (POL[k] == 0), 1'b1, 16'd0, 16'd0}));
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
